// File: rtl/pipe_pkg.sv
// Shared constants for the ID stage: opcodes, ALU op codes, stall lengths
// and the stall FSM state encoding.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8;

   // Total stall cycles, counting the cycle in which the hazard is detected.
   localparam logic [1:0] STALL_EX   = 2'd2;
   localparam logic [1:0] STALL_MEM  = 2'd1;
   localparam logic [1:0] STALL_LOAD = 2'd1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } stall_state_t;

   function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
      logic [3:0] op;
      case (funct)
         6'h20, 6'h21: op = ALU_ADD;
         6'h22, 6'h23: op = ALU_SUB;
         6'h24:        op = ALU_AND;
         6'h25:        op = ALU_OR;
         6'h26:        op = ALU_XOR;
         6'h27:        op = ALU_NOR;
         6'h2a:        op = ALU_SLT;
         6'h00:        op = ALU_SLL;
         6'h02:        op = ALU_SRL;
         default:      op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pipe_regfile.sv
// Two-read, one-write register file; r0 is hard-wired to zero and a write in
// the same cycle as a read of that register is passed straight through.
module pipe_regfile #(
   parameter int  DATA_W = 32,
   parameter int  REG_N  = 32,
   localparam int AW     = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [REG_N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
      if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
   end

endmodule

// File: rtl/pipe_id_fwd.sv
// Instruction-decode stage: decode, operand read with EX/MEM/WB bypass,
// hazard stall FSM, branch resolution in ID and the ID/EX pipeline register.
module pipe_id_fwd
   import pipe_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  REG_N  = 32,
   parameter int  FWD_EN = 1,
   localparam int AW     = $clog2(REG_N)
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_valid,
   input  logic [31:0]       in_npc,
   input  logic [31:0]       in_instruction,
   input  logic [AW-1:0]     in_ex_waddr,
   input  logic              in_ex_wena,
   input  logic              in_ex_is_load,
   input  logic [DATA_W-1:0] in_ex_result,
   input  logic [AW-1:0]     in_mem_waddr,
   input  logic              in_mem_wena,
   input  logic [DATA_W-1:0] in_mem_result,
   input  logic [AW-1:0]     in_wb_waddr,
   input  logic              in_wb_wena,
   input  logic [DATA_W-1:0] in_wb_data,
   input  logic              in_ex_stall,
   output logic              out_stall,
   output logic              out_branch,
   output logic [31:0]       out_pc_target,
   output logic              out_valid,
   output logic [31:0]       out_npc,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_immed,
   output logic [AW-1:0]     out_waddr,
   output logic              out_wena,
   output logic              out_is_load,
   output logic              out_is_store,
   output logic              out_alu_b_sel,
   output logic [3:0]        out_alu_op
);

   logic [5:0]  op;
   logic [4:0]  rs_f, rt_f, rd_f;
   logic [15:0] imm;
   logic [31:0] imm32;
   logic [AW-1:0] rs_addr, rt_addr, dec_waddr;
   logic [DATA_W-1:0] dec_immed;
   logic uses_rs, uses_rt, dec_wena, dec_load, dec_store, dec_b_sel;
   logic is_beq, is_bne, is_j;
   logic [3:0] dec_alu_op;

   assign op      = in_instruction[31:26];
   assign rs_f    = in_instruction[25:21];
   assign rt_f    = in_instruction[20:16];
   assign rd_f    = in_instruction[15:11];
   assign imm     = in_instruction[15:0];
   assign imm32   = {{16{imm[15]}}, imm};
   assign rs_addr = rs_f[AW-1:0];
   assign rt_addr = rt_f[AW-1:0];
   assign dec_immed = {{(DATA_W-16){imm[15]}}, imm};

   always_comb begin
      uses_rs    = 1'b0;
      uses_rt    = 1'b0;
      dec_wena   = 1'b0;
      dec_waddr  = '0;
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_b_sel  = 1'b0;
      dec_alu_op = ALU_ADD;
      is_beq     = 1'b0;
      is_bne     = 1'b0;
      is_j       = 1'b0;
      case (op)
         OP_RTYPE: begin
            uses_rs = 1'b1; uses_rt = 1'b1;
            dec_wena = 1'b1; dec_waddr = rd_f[AW-1:0];
            dec_alu_op = funct_to_alu(in_instruction[5:0]);
         end
         OP_ADDI: begin
            uses_rs = 1'b1; dec_wena = 1'b1; dec_waddr = rt_addr; dec_b_sel = 1'b1;
         end
         OP_LW: begin
            uses_rs = 1'b1; dec_wena = 1'b1; dec_waddr = rt_addr;
            dec_load = 1'b1; dec_b_sel = 1'b1;
         end
         OP_SW: begin
            uses_rs = 1'b1; uses_rt = 1'b1; dec_store = 1'b1; dec_b_sel = 1'b1;
         end
         OP_BEQ: begin
            uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; dec_alu_op = ALU_SUB;
         end
         OP_BNE: begin
            uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; dec_alu_op = ALU_SUB;
         end
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val;

   pipe_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
      .clk   (in_clk),
      .rst_n (in_rst),
      .ra1   (rs_addr),
      .ra2   (rt_addr),
      .rd1   (rf_rs),
      .rd2   (rf_rt),
      .we    (in_wb_wena),
      .wa    (in_wb_waddr),
      .wd    (in_wb_data)
   );

   logic ex_rs, ex_rt, mem_rs, mem_rt, ex_hit, mem_hit;

   assign ex_rs   = in_ex_wena  && (in_ex_waddr  == rs_addr) && (rs_addr != '0);
   assign ex_rt   = in_ex_wena  && (in_ex_waddr  == rt_addr) && (rt_addr != '0);
   assign mem_rs  = in_mem_wena && (in_mem_waddr == rs_addr) && (rs_addr != '0);
   assign mem_rt  = in_mem_wena && (in_mem_waddr == rt_addr) && (rt_addr != '0);
   assign ex_hit  = (uses_rs && ex_rs)  || (uses_rt && ex_rt);
   assign mem_hit = (uses_rs && mem_rs) || (uses_rt && mem_rt);

   // WB bypass lives in the regfile, so only EX and MEM are muxed here.
   always_comb begin
      rs_val = rf_rs;
      rt_val = rf_rt;
      if (FWD_EN != 0) begin
         if (ex_rs)       rs_val = in_ex_result;
         else if (mem_rs) rs_val = in_mem_result;
         if (ex_rt)       rt_val = in_ex_result;
         else if (mem_rt) rt_val = in_mem_result;
      end
   end

   logic       hazard;
   logic [1:0] stall_len;

   always_comb begin
      hazard    = 1'b0;
      stall_len = STALL_LOAD;
      if (FWD_EN != 0) begin
         hazard    = in_valid && ex_hit && (in_ex_is_load || is_beq || is_bne);
         stall_len = STALL_LOAD;
      end else begin
         hazard    = in_valid && (ex_hit || mem_hit);
         stall_len = ex_hit ? STALL_EX : STALL_MEM;
      end
   end

   stall_state_t state;
   logic [1:0]   cnt;
   logic         hold_stall, hazard_stall, bubble, take;

   // Once the counter has expired, HOLD evaluates hazards exactly like RUN.
   assign hold_stall   = (state == ST_HOLD) && (cnt != 2'd0);
   assign hazard_stall = !hold_stall && hazard;
   assign bubble       = !in_valid || hazard_stall || hold_stall;
   assign out_stall    = in_rst && (in_ex_stall || hazard_stall || hold_stall);

   assign take = is_j || (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
   assign out_branch    = in_rst && in_valid && !out_stall && take;
   assign out_pc_target = is_j ? {in_npc[31:28], in_instruction[25:0], 2'b00}
                               : in_npc + {imm32[29:0], 2'b00};

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state <= ST_RUN;
         cnt   <= 2'd0;
      end else if (!in_ex_stall) begin
         if (hold_stall) begin
            cnt <= cnt - 2'd1;
         end else if (hazard) begin
            state <= ST_HOLD;
            cnt   <= stall_len - 2'd1;
         end else begin
            state <= ST_RUN;
            cnt   <= 2'd0;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst || (!in_ex_stall && bubble)) begin
         out_valid     <= 1'b0;
         out_npc       <= '0;
         out_rs_data   <= '0;
         out_rt_data   <= '0;
         out_immed     <= '0;
         out_waddr     <= '0;
         out_wena      <= 1'b0;
         out_is_load   <= 1'b0;
         out_is_store  <= 1'b0;
         out_alu_b_sel <= 1'b0;
         out_alu_op    <= ALU_ADD;
      end else if (!in_ex_stall) begin
         out_valid     <= 1'b1;
         out_npc       <= in_npc;
         out_rs_data   <= rs_val;
         out_rt_data   <= rt_val;
         out_immed     <= dec_immed;
         out_waddr     <= dec_waddr;
         out_wena      <= dec_wena;
         out_is_load   <= dec_load;
         out_is_store  <= dec_store;
         out_alu_b_sel <= dec_b_sel;
         out_alu_op    <= dec_alu_op;
      end
   end

endmodule

// File: tb/tb_pipe_id_fwd.sv
// Directed bench for pipe_id_fwd: one instance with forwarding, one stall-only,
// both driven from the same inputs.
module tb_pipe_id_fwd;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          in_clk = 1'b0;
   logic          in_rst = 1'b0;
   logic          in_valid;
   logic [31:0]   in_npc, in_instruction;
   logic [AW-1:0] in_ex_waddr, in_mem_waddr, in_wb_waddr;
   logic          in_ex_wena, in_ex_is_load, in_mem_wena, in_wb_wena, in_ex_stall;
   logic [DW-1:0] in_ex_result, in_mem_result, in_wb_data;

   logic f_stall, f_branch, f_valid, f_wena, f_is_load, f_is_store, f_alu_b_sel;
   logic [31:0] f_pc_target, f_npc;
   logic [DW-1:0] f_rs_data, f_rt_data, f_immed;
   logic [AW-1:0] f_waddr;
   logic [3:0] f_alu_op;
   logic s_stall, s_branch, s_valid, s_wena, s_is_load, s_is_store, s_alu_b_sel;
   logic [31:0] s_pc_target, s_npc;
   logic [DW-1:0] s_rs_data, s_rt_data, s_immed;
   logic [AW-1:0] s_waddr;
   logic [3:0] s_alu_op;

   int checks = 0;
   int fails  = 0;

   always #5 in_clk = ~in_clk;

   pipe_id_fwd #(.DATA_W(DW), .REG_N(32), .FWD_EN(1)) u_fwd (
      .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_npc(in_npc),
      .in_instruction(in_instruction), .in_ex_waddr(in_ex_waddr), .in_ex_wena(in_ex_wena),
      .in_ex_is_load(in_ex_is_load), .in_ex_result(in_ex_result), .in_mem_waddr(in_mem_waddr),
      .in_mem_wena(in_mem_wena), .in_mem_result(in_mem_result), .in_wb_waddr(in_wb_waddr),
      .in_wb_wena(in_wb_wena), .in_wb_data(in_wb_data), .in_ex_stall(in_ex_stall),
      .out_stall(f_stall), .out_branch(f_branch), .out_pc_target(f_pc_target),
      .out_valid(f_valid), .out_npc(f_npc), .out_rs_data(f_rs_data), .out_rt_data(f_rt_data),
      .out_immed(f_immed), .out_waddr(f_waddr), .out_wena(f_wena), .out_is_load(f_is_load),
      .out_is_store(f_is_store), .out_alu_b_sel(f_alu_b_sel), .out_alu_op(f_alu_op)
   );

   pipe_id_fwd #(.DATA_W(DW), .REG_N(32), .FWD_EN(0)) u_stl (
      .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_npc(in_npc),
      .in_instruction(in_instruction), .in_ex_waddr(in_ex_waddr), .in_ex_wena(in_ex_wena),
      .in_ex_is_load(in_ex_is_load), .in_ex_result(in_ex_result), .in_mem_waddr(in_mem_waddr),
      .in_mem_wena(in_mem_wena), .in_mem_result(in_mem_result), .in_wb_waddr(in_wb_waddr),
      .in_wb_wena(in_wb_wena), .in_wb_data(in_wb_data), .in_ex_stall(in_ex_stall),
      .out_stall(s_stall), .out_branch(s_branch), .out_pc_target(s_pc_target),
      .out_valid(s_valid), .out_npc(s_npc), .out_rs_data(s_rs_data), .out_rt_data(s_rt_data),
      .out_immed(s_immed), .out_waddr(s_waddr), .out_wena(s_wena), .out_is_load(s_is_load),
      .out_is_store(s_is_store), .out_alu_b_sel(s_alu_b_sel), .out_alu_op(s_alu_op)
   );

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_npc = '0; in_instruction = '0;
      in_ex_waddr = '0; in_ex_wena = 0; in_ex_is_load = 0; in_ex_result = '0;
      in_mem_waddr = '0; in_mem_wena = 0; in_mem_result = '0;
      in_wb_waddr = '0; in_wb_wena = 0; in_wb_data = '0; in_ex_stall = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      in_rst = 0;
      repeat (2) @(posedge in_clk);
      @(negedge in_clk);
      in_rst = 1;
      tick();
   endtask

   // r1=10, r2=20, r4=0x44, r6=7
   task automatic preload();
      in_wb_wena = 1;
      in_wb_waddr = 5'd1; in_wb_data = 32'd10;   tick();
      in_wb_waddr = 5'd2; in_wb_data = 32'd20;   tick();
      in_wb_waddr = 5'd4; in_wb_data = 32'h44;   tick();
      in_wb_waddr = 5'd6; in_wb_data = 32'd7;    tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      in_rst = 0;
      repeat (2) @(posedge in_clk);
      #2;
      checks++; if (f_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h want 0", f_valid); end
      checks++; if (f_rs_data !== 32'd0) begin fails++; $display("FAIL reset_rs: got %0h want 0", f_rs_data); end
      checks++; if (f_npc !== 32'd0) begin fails++; $display("FAIL reset_npc: got %0h want 0", f_npc); end
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0h want 0", f_stall); end
      checks++; if (f_branch !== 1'b0) begin fails++; $display("FAIL reset_branch: got %0h want 0", f_branch); end
      checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_s_valid: got %0h want 0", s_valid); end
      @(negedge in_clk);
      in_rst = 1;
      tick();
   endtask

   task automatic test_fwd_ex();
      in_valid = 1; in_npc = 32'h40; in_instruction = enc_r(1, 2, 3, 6'h20);
      in_ex_waddr = 5'd1; in_ex_wena = 1; in_ex_result = 32'd5;
      #2;
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL fwd_ex_stall: got %0h want 0", f_stall); end
      tick();
      checks++; if (f_rs_data !== 32'd5) begin fails++; $display("FAIL fwd_ex_rs: got %0h want 5", f_rs_data); end
      checks++; if (f_rt_data !== 32'd20) begin fails++; $display("FAIL fwd_ex_rt: got %0h want 14", f_rt_data); end
      checks++; if (f_waddr !== 5'd3 || f_wena !== 1'b1 || f_valid !== 1'b1) begin
         fails++; $display("FAIL fwd_ex_ctl: got waddr=%0d wena=%0b valid=%0b want 3/1/1", f_waddr, f_wena, f_valid); end
      checks++; if (f_npc !== 32'h40 || f_alu_op !== 4'd0) begin
         fails++; $display("FAIL fwd_ex_npc_op: got %0h/%0h want 40/0", f_npc, f_alu_op); end
      // EX disabled, MEM hits r1, WB writes r6 in the same cycle
      in_instruction = enc_r(1, 6, 3, 6'h22); in_ex_wena = 0;
      in_mem_waddr = 5'd1; in_mem_wena = 1; in_mem_result = 32'd9;
      in_wb_waddr = 5'd6; in_wb_wena = 1; in_wb_data = 32'h66;
      tick();
      checks++; if (f_rs_data !== 32'd9) begin fails++; $display("FAIL fwd_mem_rs: got %0h want 9", f_rs_data); end
      checks++; if (f_rt_data !== 32'h66) begin fails++; $display("FAIL fwd_wb_rt: got %0h want 66", f_rt_data); end
      checks++; if (f_alu_op !== 4'd1) begin fails++; $display("FAIL fwd_sub_op: got %0h want 1", f_alu_op); end
      in_wb_wena = 0;
      in_instruction = enc_r(1, 1, 3, 6'h24); in_ex_wena = 1; in_ex_waddr = 5'd1;
      tick();
      checks++; if (f_rs_data !== 32'd5 || f_rt_data !== 32'd5) begin
         fails++; $display("FAIL fwd_ex_over_mem: got %0h/%0h want 5/5", f_rs_data, f_rt_data); end
      checks++; if (f_alu_op !== 4'd2) begin fails++; $display("FAIL fwd_and_op: got %0h want 2", f_alu_op); end
      in_instruction = enc_r(0, 2, 3, 6'h20); in_ex_waddr = 5'd0; in_ex_result = 32'h77;
      in_mem_waddr = 5'd0; in_mem_result = 32'h88;
      tick();
      checks++; if (f_rs_data !== 32'd0 || f_rt_data !== 32'd20) begin
         fails++; $display("FAIL fwd_r0: got %0h/%0h want 0/14", f_rs_data, f_rt_data); end
      clear_inputs();
      tick();
   endtask

   task automatic test_decode();
      in_valid = 1; in_npc = 32'h50; in_instruction = enc_i(6'b101011, 1, 2, 16'h0008);
      tick();
      checks++; if (f_is_store !== 1'b1 || f_wena !== 1'b0 || f_alu_b_sel !== 1'b1) begin
         fails++; $display("FAIL dec_sw_ctl: got st=%0b wena=%0b bsel=%0b want 1/0/1", f_is_store, f_wena, f_alu_b_sel); end
      checks++; if (f_rs_data !== 32'd10 || f_rt_data !== 32'd20 || f_immed !== 32'd8) begin
         fails++; $display("FAIL dec_sw_data: got %0h/%0h/%0h want a/14/8", f_rs_data, f_rt_data, f_immed); end
      in_instruction = enc_i(6'b100011, 1, 7, 16'hFFFC);
      tick();
      checks++; if (f_is_load !== 1'b1 || f_wena !== 1'b1 || f_waddr !== 5'd7) begin
         fails++; $display("FAIL dec_lw_ctl: got ld=%0b wena=%0b waddr=%0d want 1/1/7", f_is_load, f_wena, f_waddr); end
      checks++; if (f_immed !== 32'hFFFF_FFFC) begin fails++; $display("FAIL dec_lw_sext: got %0h want fffffffc", f_immed); end
      in_instruction = enc_i(6'b001000, 6, 8, 16'h7FFF);
      tick();
      checks++; if (f_immed !== 32'h7FFF || f_waddr !== 5'd8 || f_rs_data !== 32'h66) begin
         fails++; $display("FAIL dec_addi: got %0h/%0d/%0h want 7fff/8/66", f_immed, f_waddr, f_rs_data); end
      in_instruction = enc_i(6'h3F, 1, 1, 16'h0);
      in_ex_waddr = 5'd1; in_ex_wena = 1; in_ex_is_load = 1;
      #2;
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL dec_nop_stall: got %0h want 0", f_stall); end
      tick();
      checks++; if (f_wena !== 1'b0 || f_is_store !== 1'b0) begin
         fails++; $display("FAIL dec_nop_ctl: got wena=%0b st=%0b want 0/0", f_wena, f_is_store); end
      in_valid = 0; in_instruction = enc_r(1, 2, 3, 6'h20);
      #2;
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL invalid_stall: got %0h want 0", f_stall); end
      tick();
      checks++; if (f_valid !== 1'b0 || f_wena !== 1'b0) begin
         fails++; $display("FAIL invalid_bubble: got valid=%0b wena=%0b want 0/0", f_valid, f_wena); end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_use();
      in_valid = 1; in_npc = 32'h60; in_instruction = enc_r(4, 4, 5, 6'h20);
      in_ex_waddr = 5'd4; in_ex_wena = 1; in_ex_is_load = 1; in_ex_result = 32'hDEAD;
      #2;
      checks++; if (f_stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %0h want 1", f_stall); end
      tick();
      checks++; if (f_valid !== 1'b0 || f_wena !== 1'b0) begin
         fails++; $display("FAIL lu_bubble: got valid=%0b wena=%0b want 0/0", f_valid, f_wena); end
      in_ex_wena = 0; in_ex_is_load = 0;
      in_mem_waddr = 5'd4; in_mem_wena = 1; in_mem_result = 32'h1234;
      #2;
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %0h want 0", f_stall); end
      tick();
      checks++; if (f_valid !== 1'b1 || f_rs_data !== 32'h1234 || f_rt_data !== 32'h1234 || f_waddr !== 5'd5) begin
         fails++; $display("FAIL lu_issue: got v=%0b %0h/%0h w=%0d want 1 1234/1234 5", f_valid, f_rs_data, f_rt_data, f_waddr); end
      clear_inputs();
      tick();
   endtask

   task automatic test_branch();
      in_valid = 1; in_npc = 32'h100; in_instruction = enc_i(6'b000100, 1, 1, 16'd4);
      #2;
      checks++; if (f_branch !== 1'b1 || f_pc_target !== 32'h110) begin
         fails++; $display("FAIL beq_taken: got %0b/%0h want 1/110", f_branch, f_pc_target); end
      in_valid = 0;
      #2;
      checks++; if (f_branch !== 1'b0) begin fails++; $display("FAIL beq_invalid: got %0b want 0", f_branch); end
      in_valid = 1; in_npc = 32'h200; in_instruction = enc_i(6'b000101, 1, 2, 16'hFFFE);
      #2;
      checks++; if (f_branch !== 1'b1 || f_pc_target !== 32'h1F8) begin
         fails++; $display("FAIL bne_taken: got %0b/%0h want 1/1f8", f_branch, f_pc_target); end
      in_instruction = enc_i(6'b000101, 1, 1, 16'hFFFE);
      #2;
      checks++; if (f_branch !== 1'b0) begin fails++; $display("FAIL bne_not: got %0b want 0", f_branch); end
      in_npc = 32'h3000_0004; in_instruction = {6'b000010, 26'h40};
      #2;
      checks++; if (f_branch !== 1'b1 || f_pc_target !== 32'h3000_0100) begin
         fails++; $display("FAIL j_target: got %0b/%0h want 1/30000100", f_branch, f_pc_target); end
      in_npc = 32'h100; in_instruction = enc_i(6'b000100, 1, 2, 16'd4);
      in_mem_waddr = 5'd2; in_mem_wena = 1; in_mem_result = 32'd10;
      #2;
      checks++; if (f_branch !== 1'b1) begin fails++; $display("FAIL beq_mem_fwd: got %0b want 1", f_branch); end
      in_mem_wena = 0; in_instruction = enc_i(6'b000100, 1, 1, 16'd4);
      in_ex_waddr = 5'd1; in_ex_wena = 1; in_ex_result = 32'd3;
      #2;
      checks++; if (f_stall !== 1'b1 || f_branch !== 1'b0) begin
         fails++; $display("FAIL beq_ex_hazard: got stall=%0b br=%0b want 1/0", f_stall, f_branch); end
      tick();
      in_ex_wena = 0;
      #2;
      checks++; if (f_stall !== 1'b0 || f_branch !== 1'b1) begin
         fails++; $display("FAIL beq_after_stall: got stall=%0b br=%0b want 0/1", f_stall, f_branch); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_ex_stall();
      in_valid = 1; in_npc = 32'h80; in_instruction = enc_r(1, 2, 3, 6'h20);
      tick();
      checks++; if (f_valid !== 1'b1 || f_rs_data !== 32'd10) begin
         fails++; $display("FAIL exs_setup: got %0b/%0h want 1/a", f_valid, f_rs_data); end
      in_npc = 32'h84; in_instruction = enc_r(4, 4, 5, 6'h20);
      in_ex_waddr = 5'd4; in_ex_wena = 1; in_ex_is_load = 1; in_ex_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++; if (f_stall !== 1'b1) begin fails++; $display("FAIL exs_stall_%0d: got %0b want 1", i, f_stall); end
         tick();
         checks++; if (f_valid !== 1'b1 || f_rs_data !== 32'd10 || f_npc !== 32'h80) begin
            fails++; $display("FAIL exs_hold_%0d: got %0b/%0h/%0h want 1/a/80", i, f_valid, f_rs_data, f_npc); end
      end
      in_ex_stall = 0;
      #2;
      checks++; if (f_stall !== 1'b1) begin fails++; $display("FAIL exs_lu_stall: got %0b want 1", f_stall); end
      tick();
      checks++; if (f_valid !== 1'b0) begin fails++; $display("FAIL exs_bubble: got %0b want 0", f_valid); end
      in_ex_wena = 0; in_ex_is_load = 0;
      in_mem_waddr = 5'd4; in_mem_wena = 1; in_mem_result = 32'h55;
      #2;
      checks++; if (f_stall !== 1'b0) begin fails++; $display("FAIL exs_release: got %0b want 0", f_stall); end
      tick();
      checks++; if (f_valid !== 1'b1 || f_rs_data !== 32'h55 || f_npc !== 32'h84) begin
         fails++; $display("FAIL exs_issue: got %0b/%0h/%0h want 1/55/84", f_valid, f_rs_data, f_npc); end
      clear_inputs();
      tick();
   endtask

   task automatic test_stall_only();
      do_reset();
      preload();
      in_valid = 1; in_npc = 32'h10; in_instruction = enc_r(1, 2, 3, 6'h20);
      in_ex_waddr = 5'd1; in_ex_wena = 1; in_ex_result = 32'd5;
      #2;
      checks++; if (s_stall !== 1'b1) begin fails++; $display("FAIL so_stall_a: got %0b want 1", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL so_bubble_a: got %0b want 0", s_valid); end
      in_ex_wena = 0; in_mem_waddr = 5'd1; in_mem_wena = 1; in_mem_result = 32'd5;
      #2;
      checks++; if (s_stall !== 1'b1) begin fails++; $display("FAIL so_stall_b: got %0b want 1", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL so_bubble_b: got %0b want 0", s_valid); end
      in_mem_wena = 0; in_wb_waddr = 5'd1; in_wb_wena = 1; in_wb_data = 32'd5;
      #2;
      checks++; if (s_stall !== 1'b0) begin fails++; $display("FAIL so_release: got %0b want 0", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b1 || s_rs_data !== 32'd5 || s_rt_data !== 32'd20 || s_npc !== 32'h10) begin
         fails++; $display("FAIL so_issue: got %0b %0h/%0h %0h want 1 5/14 10", s_valid, s_rs_data, s_rt_data, s_npc); end
      in_wb_wena = 0; in_instruction = enc_r(2, 1, 3, 6'h20);
      in_mem_waddr = 5'd2; in_mem_wena = 1; in_mem_result = 32'h99;
      #2;
      checks++; if (s_stall !== 1'b1) begin fails++; $display("FAIL so_mem_stall: got %0b want 1", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL so_mem_bubble: got %0b want 0", s_valid); end
      in_mem_wena = 0;
      #2;
      checks++; if (s_stall !== 1'b0) begin fails++; $display("FAIL so_mem_release: got %0b want 0", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b1 || s_rs_data !== 32'd20 || s_rt_data !== 32'd5) begin
         fails++; $display("FAIL so_no_fwd: got %0b %0h/%0h want 1 14/5", s_valid, s_rs_data, s_rt_data); end
      // Counter must not count down while downstream is held.
      in_ex_waddr = 5'd1; in_ex_wena = 1;
      tick();
      in_ex_wena = 0; in_ex_stall = 1;
      for (int i = 0; i < 2; i++) begin
         #2;
         checks++; if (s_stall !== 1'b1) begin fails++; $display("FAIL so_frz_stall_%0d: got %0b want 1", i, s_stall); end
         tick();
      end
      in_ex_stall = 0;
      #2;
      checks++; if (s_stall !== 1'b1) begin fails++; $display("FAIL so_frz_release: got %0b want 1", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL so_frz_bubble: got %0b want 0", s_valid); end
      #2;
      checks++; if (s_stall !== 1'b0) begin fails++; $display("FAIL so_frz_done: got %0b want 0", s_stall); end
      tick();
      checks++; if (s_valid !== 1'b1) begin fails++; $display("FAIL so_frz_issue: got %0b want 1", s_valid); end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      in_valid = 1; in_npc = 32'h20; in_instruction = enc_r(1, 2, 3, 6'h20);
      tick();
      in_ex_waddr = 5'd1; in_ex_wena = 1; in_ex_result = 32'd5;
      tick();
      #2;
      checks++; if (s_stall !== 1'b1 || f_valid !== 1'b1) begin
         fails++; $display("FAIL rm_pre: got s_stall=%0b f_valid=%0b want 1/1", s_stall, f_valid); end
      in_rst = 0;
      #1;
      checks++; if (f_valid !== 1'b0 || f_npc !== 32'd0 || f_rs_data !== 32'd0 || f_waddr !== 5'd0 || f_wena !== 1'b0) begin
         fails++; $display("FAIL rm_clear: got %0b %0h %0h %0d %0b want all 0", f_valid, f_npc, f_rs_data, f_waddr, f_wena); end
      checks++; if (s_stall !== 1'b0 || f_stall !== 1'b0 || f_branch !== 1'b0) begin
         fails++; $display("FAIL rm_stall: got %0b/%0b/%0b want 0/0/0", s_stall, f_stall, f_branch); end
      @(negedge in_clk);
      in_rst = 1;
      in_ex_wena = 0;
      #1;
      checks++; if (s_stall !== 1'b0) begin fails++; $display("FAIL rm_run: got %0b want 0", s_stall); end
      tick();
      checks++; if (f_rs_data !== 32'd0 || f_rt_data !== 32'd0) begin
         fails++; $display("FAIL rm_regs_cleared: got %0h/%0h want 0/0", f_rs_data, f_rt_data); end
      in_instruction = enc_r(0, 0, 3, 6'h20);
      in_wb_waddr = 5'd0; in_wb_wena = 1; in_wb_data = 32'hFFFF;
      tick();
      checks++; if (f_rs_data !== 32'd0) begin fails++; $display("FAIL r0_wthru: got %0h want 0", f_rs_data); end
      in_wb_wena = 0;
      tick();
      checks++; if (f_rs_data !== 32'd0 || f_rt_data !== 32'd0) begin
         fails++; $display("FAIL r0_read: got %0h/%0h want 0/0", f_rs_data, f_rt_data); end
      in_instruction = enc_r(9, 0, 3, 6'h20);
      in_wb_waddr = 5'd9; in_wb_wena = 1; in_wb_data = 32'h1F;
      tick();
      checks++; if (f_rs_data !== 32'h1F) begin fails++; $display("FAIL r9_wthru: got %0h want 1f", f_rs_data); end
      clear_inputs();
      tick();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      preload();
      test_fwd_ex();
      test_decode();
      test_load_use();
      test_branch();
      test_ex_stall();
      test_stall_only();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
